// File: rtl/seg_scroll.sv
// seg_scroll: scrolling 7-segment message display.
// A small message buffer of hex digits with decimal points is shown through
// a DIGITS-wide window. The window offset advances once per prescaler tick,
// can be paused and single-stepped, and the whole display can blink.
//
// Write port: fire-and-forget. There is no ready; an entry is accepted on
// every rising edge where wr_en is high and wr_addr is inside the buffer.
// Out-of-range addresses are dropped silently.
//
// o_state exposes the scroll FSM (0 = RUN, 1 = HOLD) for observation.

module seg_scroll #(
  parameter int DIGITS     = 8,
  parameter int MSG_LEN    = 16,
  parameter int CLK_DIV    = 5000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [4:0]                 wr_data,
  input  logic                       dir,
  input  logic                       pause,
  input  logic                       step,
  input  logic                       blink_en,
  output logic [8*DIGITS-1:0]        o_seg,
  output logic [$clog2(MSG_LEN)-1:0] o_offset,
  output logic                       o_tick,
  output logic                       o_state
);

  // ---------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------
  localparam int AW = $clog2(MSG_LEN);
  localparam int CW = $clog2(CLK_DIV);
  localparam int SW = 8 * DIGITS;

  localparam logic STATE_RUN  = 1'b0;
  localparam logic STATE_HOLD = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);
  // One extra bit so MSG_LEN itself is representable for wrap compares.
  localparam logic [AW:0]   LEN_EXT  = (AW + 1)'(MSG_LEN);

  // ---------------------------------------------------------------------
  // Parameter sanity, caught at elaboration
  // ---------------------------------------------------------------------
  if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
    $error("seg_scroll: DIGITS must be in 1..16");
  end
  if (MSG_LEN < DIGITS || MSG_LEN < 2) begin : g_bad_len
    $error("seg_scroll: MSG_LEN must be >= DIGITS and >= 2");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("seg_scroll: CLK_DIV must be >= 2");
  end

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Hex nibble to segments a..g (a in the MSB).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // One buffer entry to an 8-bit digit: decode, blank, then apply polarity.
  function automatic logic [7:0] digit_bits(input logic [4:0] entry,
                                            input logic       blank);
    logic [7:0] b;
    b = blank ? 8'h00 : {hex_to_seg(entry[3:0]), entry[4]};
    if (ACTIVE_LOW != 0) begin
      b = ~b;
    end
    return b;
  endfunction

  // (off + k) mod MSG_LEN without relying on power-of-two truncation.
  // off < MSG_LEN and k < DIGITS <= MSG_LEN, so one subtraction suffices.
  function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] off,
                                             input int            k);
    logic [AW:0] s;
    s = {1'b0, off} + (AW + 1)'(k);
    if (s >= LEN_EXT) begin
      s = s - LEN_EXT;
    end
    return s[AW-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CW-1:0] r_count;
  logic          r_state;
  logic [AW-1:0] r_offset;
  logic          r_phase;
  logic [4:0]    r_buf [MSG_LEN];
  logic [SW-1:0] r_seg;

  logic          w_tick;
  logic          w_advance;
  logic          w_wr_hit;
  logic [AW-1:0] w_next_offset;
  logic [SW-1:0] w_seg_next;
  logic [SW-1:0] w_seg_rst;

  // ---------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------

  // Tick is the last count value; it runs in every FSM state.
  always_comb begin
    w_tick = (r_count == CNT_LAST);
  end

  // Free-running 0..CLK_DIV-1 counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Scroll FSM and offset
  // ---------------------------------------------------------------------

  // RUN advances on ticks; HOLD advances only on step. Step in RUN is
  // ignored, so at most one advance can happen per edge.
  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      STATE_RUN:  w_advance = !pause && w_tick;
      STATE_HOLD: w_advance = step;
      default:    w_advance = 1'b0;
    endcase
  end

  // Offset one position left or right, wrapping at the buffer ends.
  always_comb begin
    w_next_offset = r_offset;
    if (!dir) begin
      w_next_offset = (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
    end else begin
      w_next_offset = (r_offset == '0) ? OFF_LAST : r_offset - 1'b1;
    end
  end

  // Next state simply follows the pause level every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STATE_RUN;
    end else begin
      r_state <= pause ? STATE_HOLD : STATE_RUN;
    end
  end

  // Scroll offset register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset <= '0;
    end else if (w_advance) begin
      r_offset <= w_next_offset;
    end
  end

  // ---------------------------------------------------------------------
  // Blink phase
  // ---------------------------------------------------------------------

  // Toggle per tick while blinking; parked at "visible" otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 1'b0;
    end else if (!blink_en) begin
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_phase <= ~r_phase;
    end
  end

  // ---------------------------------------------------------------------
  // Message buffer
  // ---------------------------------------------------------------------

  // Address range check; matters when MSG_LEN is not a power of two.
  always_comb begin
    w_wr_hit = wr_en && ({1'b0, wr_addr} < LEN_EXT);
  end

  // Reset fills entry i with hex digit (i mod 16), dp off.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MSG_LEN; i++) begin
      if (rst) begin
        r_buf[i] <= {1'b0, 4'(i % 16)};
      end else if (w_wr_hit && (wr_addr == AW'(i))) begin
        r_buf[i] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Display
  // ---------------------------------------------------------------------

  // Window of DIGITS entries starting at the current offset.
  always_comb begin
    w_seg_next = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_seg_next[8*k +: 8] = digit_bits(r_buf[wrap_idx(r_offset, k)], r_phase);
    end
  end

  // Image of the reset buffer at offset 0 so o_seg is valid straight out
  // of reset instead of one cycle later.
  always_comb begin
    w_seg_rst = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_seg_rst[8*k +: 8] = digit_bits({1'b0, 4'(k % 16)}, 1'b0);
    end
  end

  // Registered segment outputs, one cycle behind buffer/offset/phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= w_seg_rst;
    end else begin
      r_seg <= w_seg_next;
    end
  end

  assign o_seg    = r_seg;
  assign o_offset = r_offset;
  assign o_tick   = w_tick;
  assign o_state  = r_state;

endmodule

// File: tb/tb_seg_scroll.sv
// Directed bench for seg_scroll with DIGITS=4, MSG_LEN=6, CLK_DIV=4,
// ACTIVE_LOW=1. Inputs change and outputs are sampled on the falling edge.

module tb_seg_scroll;

  localparam int DIGITS     = 4;
  localparam int MSG_LEN    = 6;
  localparam int CLK_DIV    = 4;
  localparam int ACTIVE_LOW = 1;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [4:0]  wr_data = 5'd0;
  logic        dir = 1'b0;
  logic        pause = 1'b0;
  logic        step = 1'b0;
  logic        blink_en = 1'b0;
  logic [31:0] o_seg;
  logic [2:0]  o_offset;
  logic        o_tick;
  logic        o_state;

  always #5 clk = ~clk;

  seg_scroll #(
    .DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dir(dir), .pause(pause), .step(step), .blink_en(blink_en),
    .o_seg(o_seg), .o_offset(o_offset), .o_tick(o_tick), .o_state(o_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-decoded windows of the reset buffer (entry i = digit i), active low,
  // digit 3 in the top byte: index = offset.
  logic [31:0] pat [6];

  typedef struct {
    logic        blink;
    logic [31:0] seg;
  } blink_vec_t;
  blink_vec_t blink_tbl [17];

  // Two reset edges, then release; returns on the falling edge after the
  // last reset edge ("n = 0").
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin : main
    int ticks;
    int guard;
    int idx;

    pat[0] = 32'h0D259F03;
    pat[1] = 32'h990D259F;
    pat[2] = 32'h49990D25;
    pat[3] = 32'h0349990D;
    pat[4] = 32'h9F034999;
    pat[5] = 32'h259F0349;

    for (int i = 0; i < 17; i++) begin
      blink_tbl[i].blink = (i < 14);
      if (i < 4)        blink_tbl[i].seg = pat[0];
      else if (i < 8)   blink_tbl[i].seg = 32'hFFFFFFFF;
      else if (i < 12)  blink_tbl[i].seg = pat[2];
      else if (i < 15)  blink_tbl[i].seg = 32'hFFFFFFFF;
      else if (i == 15) blink_tbl[i].seg = pat[3];
      else              blink_tbl[i].seg = pat[4];
    end

    // --- Idle scrolling left, full wrap -------------------------------
    do_reset();
    check("rst_seg", o_seg, 32'h0D259F03);
    check("rst_state", {31'd0, o_state}, 32'd0);
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) @(negedge clk);
      exp_q.push_back(pat[(n == 0) ? 0 : ((n - 1) / 4) % 6]);
      check($sformatf("idle_off n=%0d", n), {29'd0, o_offset}, 32'((n / 4) % 6));
      check($sformatf("idle_tick n=%0d", n), {31'd0, o_tick}, 32'((n % 4) == 3));
      check($sformatf("idle_seg n=%0d", n), o_seg, exp_q.pop_front());
    end

    // --- Scroll right from reset --------------------------------------
    dir = 1'b1;
    do_reset();
    for (int n = 0; n <= 9; n++) begin
      if (n > 0) @(negedge clk);
      idx = (6 - ((n / 4) % 6)) % 6;
      check($sformatf("right_off n=%0d", n), {29'd0, o_offset}, 32'(idx));
      idx = (n == 0) ? 0 : (6 - (((n - 1) / 4) % 6)) % 6;
      check($sformatf("right_seg n=%0d", n), o_seg, pat[idx]);
    end
    dir = 1'b0;

    // --- Pause, single step, step on pause release, step in RUN -------
    pause = 1'b1;
    do_reset();
    check("pause_state_n0", {31'd0, o_state}, 32'd0);
    ticks = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (o_tick) ticks++;
      check($sformatf("pause_off n=%0d", n), {29'd0, o_offset}, 32'd0);
      if (n == 1) check("pause_state_hold", {31'd0, o_state}, 32'd1);
    end
    check("pause_tick_count", 32'(ticks), 32'd3);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("step_once", {29'd0, o_offset}, 32'd1);
    @(negedge clk);
    check("step_held", {29'd0, o_offset}, 32'd1);
    guard = 0;
    while (!o_tick && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("pause_tick_wait", {31'd0, o_tick}, 32'd1);
    step = 1'b1;
    pause = 1'b0;
    @(negedge clk);
    check("step_release_off", {29'd0, o_offset}, 32'd2);
    check("step_release_state", {31'd0, o_state}, 32'd0);
    @(negedge clk);
    step = 1'b0;
    check("step_in_run_ignored", {29'd0, o_offset}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("resume_scroll", {29'd0, o_offset}, 32'd3);

    // --- Writes: displayed, out-of-range, hidden, with advance --------
    do_reset();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'h1F;
    @(negedge clk);                                     // n=1
    check("wr_latency", o_seg, 32'h0D259F03);
    wr_addr = 3'd7; wr_data = 5'h08;
    @(negedge clk);                                     // n=2
    check("wr_digit1", o_seg, 32'h0D257003);
    wr_addr = 3'd6; wr_data = 5'h08;
    @(negedge clk);                                     // n=3
    check("wr_addr7_dropped", o_seg, 32'h0D257003);
    wr_en = 1'b0;
    @(negedge clk);                                     // n=4
    check("wr_addr6_dropped", o_seg, 32'h0D257003);
    check("wr_off1", {29'd0, o_offset}, 32'd1);
    @(negedge clk);                                     // n=5
    check("wr_off1_seg", o_seg, 32'h990D2570);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h08;
    @(negedge clk);                                     // n=6
    wr_en = 1'b0;
    check("wr_hidden_a", o_seg, 32'h990D2570);
    @(negedge clk);                                     // n=7, tick
    check("wr_hidden_b", o_seg, 32'h990D2570);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 5'h10;
    @(negedge clk);                                     // n=8
    wr_en = 1'b0;
    check("wr_adv_same_edge_a", o_seg, 32'h990D2570);
    check("wr_adv_off", {29'd0, o_offset}, 32'd2);
    @(negedge clk);                                     // n=9
    check("wr_adv_same_edge_b", o_seg, 32'h02990D25);

    // --- Blink vectors ------------------------------------------------
    do_reset();
    for (int i = 0; i < 17; i++) begin
      blink_en = blink_tbl[i].blink;
      @(negedge clk);
      check($sformatf("blink v%0d", i), o_seg, blink_tbl[i].seg);
    end
    blink_en = 1'b0;
    check("blink_end_off", {29'd0, o_offset}, 32'd4);

    // --- Reset mid-scroll overrides write/step/pause ------------------
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h1F;
    step = 1'b1; pause = 1'b1;
    @(negedge clk);
    check("midrst_seg", o_seg, 32'h0D259F03);
    check("midrst_off", {29'd0, o_offset}, 32'd0);
    check("midrst_state", {31'd0, o_state}, 32'd0);
    rst = 1'b0; wr_en = 1'b0; step = 1'b0; pause = 1'b0;
    check("midrst_tick", {31'd0, o_tick}, 32'd0);
    @(negedge clk);
    check("midrst_write_dropped", o_seg, 32'h0D259F03);
    check("midrst_off_after", {29'd0, o_offset}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on the run.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/seg_scroll.md
SEG_SCROLL -- requirements
Module: seg_scroll

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of 7-segment digits driven (1..16).
REQ-002 SHALL have parameter MSG_LEN, default 16: message buffer entries; constraint MSG_LEN >= DIGITS; need not be a power of two.
REQ-003 SHALL have parameter CLK_DIV, default 5000000: clk cycles per scroll tick (>= 2).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = segment outputs inverted (lit = 0).
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  write one buffer entry this cycle.
REQ-008 wr_addr  input  $clog2(MSG_LEN)  buffer index to write.
REQ-009 wr_data  input  5  [4] = dp, [3:0] = hex digit.
REQ-010 dir  input  1  0 = scroll left (offset+1), 1 = scroll right (offset-1).
REQ-011 pause  input  1  level; 1 = hold scrolling.
REQ-012 step  input  1  single-cycle pulse; advances offset once while held.
REQ-013 blink_en  input  1  level; 1 = display blinks at tick rate.
REQ-014 o_seg  output  8*DIGITS  digit k at bits [8k+7:8k]; bit7..bit1 = a..g, bit0 = dp; registered.
REQ-015 o_offset  output  $clog2(MSG_LEN)  current scroll offset.
REQ-016 o_tick  output  1  high for one cycle per CLK_DIV cycles.

Function
REQ-017 Prescaler count SHALL run 0..CLK_DIV-1 continuously in all states; o_tick = (count == CLK_DIV-1); count wraps to 0 on that edge.
REQ-018 FSM states RUN, HOLD; next state = HOLD if pause else RUN, evaluated every edge.
REQ-019 Advance SHALL occur on an edge when (state==RUN, pause==0, o_tick==1) or (state==HOLD, step==1); at most one advance per edge; step in RUN ignored.
REQ-020 Advance with dir=0: offset = (offset+1 == MSG_LEN) ? 0 : offset+1; dir=1: offset = (offset == 0) ? MSG_LEN-1 : offset-1.
REQ-021 Buffer entry i SHALL be written with wr_data on edge when wr_en=1 and wr_addr == i; wr_addr >= MSG_LEN SHALL be ignored with no state change.
REQ-022 Digit k SHALL show entry (offset+k) mod MSG_LEN, wrap computed explicitly (no power-of-two truncation).
REQ-023 Hex map a..g (bit7..bit1): 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111; bit0 = stored dp.
REQ-024 Blink phase SHALL toggle on every o_tick while blink_en=1 and be forced to 0 while blink_en=0; phase 1 blanks all bits of all digits (0 before polarity).
REQ-025 ACTIVE_LOW=1 SHALL invert all o_seg bits after decode and blanking.
REQ-026 o_seg SHALL be registered from current buffer, offset and phase: a write or advance at edge t appears on o_seg after edge t+1.
REQ-027 Write and advance on same edge SHALL both take effect; o_seg at t+1 reflects both.
REQ-028 Write to an entry not currently displayed SHALL not alter o_seg.

Reset
REQ-029 On rst: count=0, offset=0, state=RUN, phase=0, entry i = {dp=0, hex = i mod 16}.
REQ-030 On rst edge o_seg SHALL load decode of reset buffer at offset 0 (ACTIVE_LOW=1 digit0 = 8'h03, digit1 = 8'h9F); o_tick=0 next cycle, o_offset=0.
REQ-031 rst SHALL override wr_en, step, pause in the same cycle; reset mid-scroll aborts to reset state.

Verification (DIGITS=4, MSG_LEN=6, CLK_DIV=4, ACTIVE_LOW=1 unless stated)
REQ-032 Reset, idle 30 cycles -> o_tick every 4th cycle; o_offset 0,1,2,3,4,5,0; offset 5 shows digits 5,0,1,2 (wrap).
REQ-033 dir=1 from reset -> first tick gives o_offset=5, digit0 = ~8'hB6 = 8'h49.
REQ-034 pause=1, 12 cycles -> o_offset constant; step pulse -> +1 once; step coincident with pause drop -> one advance only.
REQ-035 wr_addr=1, wr_data=5'h1F at offset 0 -> next cycle digit1 = ~8'h8F = 8'h70; wr_addr=7 -> o_seg unchanged.
REQ-036 blink_en=1 -> o_seg alternates all-8'hFF / decoded each tick; blink_en=0 -> decoded immediately next cycle.
REQ-037 rst asserted mid-scroll with wr_en=1 -> reset state, write dropped, REQ-030 values.
